// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
// Command sequencer between a byte-serial link and an ALU. It assembles a
// frame (CMD_ALU, operand A, operand B, function byte), drives the ALU operands
// and enable, captures the ALU result on ALU_VALID, and returns the
// 2*DATA_WIDTH-bit result as two bytes, low byte first.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   RX_DATA, RX_VALID   received byte and its one-cycle strobe
//   ALU_A, ALU_B        registered operands to the ALU
//   ALU_FUN             registered function code (low FUN_BITS of function byte)
//   ALU_EN              registered ALU enable, high while in ALU_RUN
//   ALU_OUT, ALU_VALID  ALU result and its valid pulse
//   TX_DATA, TX_VALID   byte to transmitter, held until accepted
//   TX_BUSY             transmitter busy; accept = TX_VALID & ~TX_BUSY
//   BUSY                high whenever the sequencer is not idle
//   FRAME_ERR           one-cycle pulse: bad command byte or inter-byte timeout
//   OVERRUN             one-cycle pulse: byte dropped while computing/sending
module alu_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FUN_BITS   = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU    = 8'hCC,
  parameter int                    TIMEOUT    = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  input  logic                    RX_VALID,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [FUN_BITS-1:0]     ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_BUSY,
  output logic                    BUSY,
  output logic                    FRAME_ERR,
  output logic                    OVERRUN
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_A   = 3'd1,
    GET_B   = 3'd2,
    GET_FUN = 3'd3,
    ALU_RUN = 3'd4,
    TX_LO   = 3'd5,
    TX_HI   = 3'd6
  } state_t;

  // The counter holds the number of idle edges already seen; the edge that
  // would bring it to TIMEOUT is the one that aborts the frame.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                  state_r;
  logic [2*DATA_WIDTH-1:0] result_r;
  logic [7:0]              timeout_cnt_r;
  logic                    in_get_s;
  logic                    timeout_hit_s;
  logic                    overrun_s;

  // Frame-phase decode, timeout detection and dropped-byte detection.
  always_comb begin
    in_get_s      = 1'b0;
    overrun_s     = 1'b0;
    timeout_hit_s = 1'b0;
    if ((state_r == GET_A) || (state_r == GET_B) || (state_r == GET_FUN)) begin
      in_get_s = 1'b1;
    end else begin
      in_get_s = 1'b0;
    end
    // A byte arriving on the timeout edge wins over the timeout.
    if (in_get_s && !RX_VALID && (timeout_cnt_r == TO_LAST)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
    if (RX_VALID && ((state_r == ALU_RUN) || (state_r == TX_LO) || (state_r == TX_HI))) begin
      overrun_s = 1'b1;
    end else begin
      overrun_s = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      result_r      <= '0;
      timeout_cnt_r <= 8'd0;
      ALU_A         <= '0;
      ALU_B         <= '0;
      ALU_FUN       <= '0;
      ALU_EN        <= 1'b0;
      TX_DATA       <= '0;
      TX_VALID      <= 1'b0;
      BUSY          <= 1'b0;
      FRAME_ERR     <= 1'b0;
      OVERRUN       <= 1'b0;
    end else begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= overrun_s;
      // Counter runs only on idle cycles inside the frame; entry, accepted
      // bytes and the timeout itself all leave it at zero.
      if (in_get_s && !RX_VALID && !timeout_hit_s) begin
        timeout_cnt_r <= timeout_cnt_r + 8'd1;
      end else begin
        timeout_cnt_r <= 8'd0;
      end

      case (state_r)
        IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == CMD_ALU) begin
              state_r <= GET_A;
              BUSY    <= 1'b1;
            end else begin
              FRAME_ERR <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (RX_VALID) begin
            ALU_A   <= RX_DATA;
            state_r <= GET_B;
          end else if (timeout_hit_s) begin
            FRAME_ERR <= 1'b1;
            BUSY      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        GET_B: begin
          if (RX_VALID) begin
            ALU_B   <= RX_DATA;
            state_r <= GET_FUN;
          end else if (timeout_hit_s) begin
            FRAME_ERR <= 1'b1;
            BUSY      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        GET_FUN: begin
          if (RX_VALID) begin
            ALU_FUN <= RX_DATA[FUN_BITS-1:0];
            // Enable tracks the next state, so it rises together with ALU_RUN.
            ALU_EN  <= 1'b1;
            state_r <= ALU_RUN;
          end else if (timeout_hit_s) begin
            FRAME_ERR <= 1'b1;
            BUSY      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        ALU_RUN: begin
          if (ALU_VALID) begin
            result_r <= ALU_OUT;
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            TX_VALID <= 1'b1;
            ALU_EN   <= 1'b0;
            state_r  <= TX_LO;
          end
        end
        TX_LO: begin
          if (!TX_BUSY) begin
            TX_DATA <= result_r[2*DATA_WIDTH-1:DATA_WIDTH];
            state_r <= TX_HI;
          end
        end
        TX_HI: begin
          if (!TX_BUSY) begin
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          ALU_EN   <= 1'b0;
          TX_VALID <= 1'b0;
          TX_DATA  <= '0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl
// Self-checking bench for alu_cmd_ctrl: directed frames from the test plan
// plus randomized frames. A small ALU responder answers ALU_EN one cycle
// later. Expected TX bytes are queued when a frame is issued and popped by an
// independent monitor whenever a byte is accepted.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_BUSY;
  logic        BUSY;
  logic        FRAME_ERR;
  logic        OVERRUN;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  int         seen_ferr = 0;
  int         exp_ovr = 0;
  int         seen_ovr = 0;
  int         en_total = 0;
  logic       rand_busy = 1'b0;
  logic       alu_en_q = 1'b0;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_BUSY(TX_BUSY), .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Arithmetic meaning of each function code.
  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] f);
    case (f)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd2:    return {8'd0, a} * {8'd0, b};
      4'd3:    return (b == 8'd0) ? 16'hFFFF : {8'd0, a / b};
      4'd5:    return {8'd0, a | b};
      4'd6:    return {8'd0, a ^ b};
      default: return {8'd0, a & b};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One-cycle ALU: result valid the cycle after it sees ALU_EN.
  initial begin
    ALU_VALID = 1'b0;
    ALU_OUT   = 16'd0;
    forever begin
      @(negedge CLK);
      ALU_VALID = alu_en_q;
      ALU_OUT   = alu_en_q ? alu_ref(ALU_A, ALU_B, ALU_FUN) : 16'($urandom);
      alu_en_q  = ALU_EN;
    end
  end

  // Monitor: scoreboard pops, TX hold rule, enable length, pulse counts.
  initial begin
    int         run = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_data = 8'd0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        run  = 0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("tx_hold_valid", 32'(TX_VALID), 32'd1);
          chk("tx_hold_data", 32'(TX_DATA), 32'(hold_data));
        end
        if (TX_VALID && !TX_BUSY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected got=%0h exp=none", TX_DATA);
          end else begin
            chk("tx_byte", 32'(TX_DATA), 32'(exp_q.pop_front()));
          end
        end
        hold      = TX_VALID && TX_BUSY;
        hold_data = TX_DATA;
        if (ALU_EN) begin
          run++;
          en_total++;
        end else if (run != 0) begin
          chk("alu_en_len", 32'(run), 32'd2);
          run = 0;
        end
        if (FRAME_ERR) seen_ferr++;
        if (OVERRUN) seen_ovr++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_busy) TX_BUSY = ($urandom_range(0, 2) == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
    RX_DATA  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] f, input int gap);
    logic [15:0] r;
    r = alu_ref(a, b, f);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    send_byte(8'hCC);
    idle(gap);
    send_byte(a);
    idle(gap);
    send_byte(b);
    idle(gap);
    send_byte({4'($urandom), f});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_done"}, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_txv(input string name);
    int n = 0;
    while (!TX_VALID && n < 50) begin
      tick();
      n++;
    end
    chk(name, 32'(TX_VALID), 32'd1);
  endtask

  function automatic logic [31:0] out_vec();
    return {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_VALID, BUSY, FRAME_ERR} ^ {TX_DATA, 23'd0, OVERRUN};
  endfunction

  initial begin
    int         en_before;
    logic       early;
    logic [7:0] ra;
    logic [7:0] rb;
    RX_VALID = 1'b0;
    RX_DATA  = 8'd0;
    TX_BUSY  = 1'b0;
    #1;
    chk("reset_outputs", out_vec(), 32'd0);
    chk("reset_tx_data", 32'(TX_DATA), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();

    // Add: 05 + 03
    send_frame(8'h05, 8'h03, 4'h0, 0);
    wait_idle("t1");
    chk("t1_alu_a", 32'(ALU_A), 32'h05);
    chk("t1_alu_b", 32'(ALU_B), 32'h03);
    chk("t1_alu_fun", 32'(ALU_FUN), 32'h0);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Multiply with the transmitter stalled for 10 cycles on the low byte
    TX_BUSY = 1'b1;
    send_frame(8'hFF, 8'hFF, 4'h2, 0);
    wait_txv("t2_txv");
    repeat (10) begin
      chk("t2_hold_valid", 32'(TX_VALID), 32'd1);
      chk("t2_hold_data", 32'(TX_DATA), 32'h01);
      tick();
    end
    TX_BUSY = 1'b0;
    wait_idle("t2");

    // Bad command byte in IDLE
    en_before = en_total;
    send_byte(8'h12);
    exp_ferr++;
    chk("t3_ferr", 32'(FRAME_ERR), 32'd1);
    chk("t3_busy", 32'(BUSY), 32'd0);
    tick();
    chk("t3_ferr_width", 32'(FRAME_ERR), 32'd0);
    chk("t3_no_en", 32'(en_total), 32'(en_before));
    send_frame(8'h0A, 8'h02, 4'h3, 1);
    wait_idle("t3");

    // Inter-byte timeout after CC,07
    en_before = en_total;
    send_byte(8'hCC);
    send_byte(8'h07);
    early = 1'b0;
    repeat (254) begin
      tick();
      if (FRAME_ERR || !BUSY) early = 1'b1;
    end
    chk("t4_no_early_timeout", 32'(early), 32'd0);
    tick();
    exp_ferr++;
    chk("t4_ferr", 32'(FRAME_ERR), 32'd1);
    chk("t4_busy", 32'(BUSY), 32'd0);
    chk("t4_alu_a", 32'(ALU_A), 32'h07);
    chk("t4_no_en", 32'(en_total), 32'(en_before));

    // Overrun while the low byte waits
    TX_BUSY = 1'b1;
    send_frame(8'h05, 8'h03, 4'h0, 0);
    wait_txv("t5_txv");
    send_byte(8'hCC);
    exp_ovr++;
    chk("t5_overrun", 32'(OVERRUN), 32'd1);
    chk("t5_tx_data", 32'(TX_DATA), 32'h08);
    TX_BUSY = 1'b0;
    wait_idle("t5");

    // Reset while holding the high byte
    send_frame(8'h11, 8'h22, 4'h2, 0);
    wait_txv("t6_txv");
    tick();
    TX_BUSY = 1'b1;
    chk("t6_hi_valid", 32'(TX_VALID), 32'd1);
    chk("t6_hi_data", 32'(TX_DATA), 32'h02);
    RST = 1'b1;
    #1;
    chk("t6_reset_outputs", out_vec(), 32'd0);
    chk("t6_reset_tx_data", 32'(TX_DATA), 32'd0);
    exp_q.delete();
    tick();
    RST = 1'b0;
    TX_BUSY = 1'b0;
    tick();
    send_frame(8'h01, 8'h01, 4'hA, 0);
    wait_idle("t6");

    // Randomized frames with random transmitter back-pressure
    rand_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send_frame(ra, rb, 4'($urandom), int'($urandom_range(0, 3)));
      wait_idle("rand");
    end
    rand_busy = 1'b0;
    TX_BUSY = 1'b0;
    idle(4);

    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_err_count", 32'(seen_ferr), 32'(exp_ferr));
    chk("overrun_count", 32'(seen_ovr), 32'(exp_ovr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
